// File: rtl/uart_arb_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned ByteW         = 8;
    localparam int unsigned DefNCh        = 4;
    localparam int unsigned DefTimeoutCyc = 1000;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFetch    = 2'd1,
        StWaitDone = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant_idx,
    output logic            any_req
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(ptr) + i) % N_CH;
            if (!any_req && req[CH_W'(idx)]) begin
                any_req   = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART transmitter between N_CH byte streams.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_CH        = DefNCh,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
    parameter int unsigned TO_W        = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*ByteW-1:0] ch_data,
    input  logic [N_CH-1:0]       ch_valid,
    input  logic [N_CH-1:0]       ch_last,
    output logic [N_CH-1:0]       ch_ready,
    input  logic                  uart_tx_status,
    input  logic                  uart_tx_over,
    output logic [ByteW-1:0]      uart_tx_data,
    output logic                  uart_tx_data_ready,
    output logic [CH_W-1:0]       grant_ch,
    output logic                  busy,
    output logic                  timeout_err
);

    arb_state_e       state_q;
    logic [CH_W-1:0]  grant_q;
    logic [CH_W-1:0]  rr_ptr_q;
    logic [TO_W-1:0]  stall_q;
    logic [ByteW-1:0] data_q;
    logic             last_q;
    logic             data_ready_q;
    logic             busy_q;
    logic             timeout_q;

    logic [CH_W-1:0]  pick_idx;
    logic             pick_any;
    logic             sel_valid;
    logic             sel_last;
    logic [ByteW-1:0] sel_data;
    logic             handshake;
    logic [CH_W-1:0]  next_ptr;

    rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_pick (
        .req       (ch_valid),
        .ptr       (rr_ptr_q),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    assign sel_valid = ch_valid[grant_q];
    assign sel_last  = ch_last[grant_q];
    assign sel_data  = ch_data[grant_q*ByteW +: ByteW];
    assign handshake = (state_q == StFetch) && sel_valid && !uart_tx_status;
    assign next_ptr  = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + CH_W'(1);

    always_comb begin
        ch_ready          = '0;
        ch_ready[grant_q] = handshake;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            stall_q      <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            timeout_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        busy_q  <= 1'b1;
                        stall_q <= '0;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    // A byte offered on the limit cycle is still taken; abort only when idle.
                    if (handshake) begin
                        data_q       <= sel_data;
                        last_q       <= sel_last;
                        stall_q      <= '0;
                        data_ready_q <= 1'b1;
                        state_q      <= StWaitDone;
                    end else if (!sel_valid) begin
                        if (stall_q == TO_W'(TIMEOUT_CYC - 1)) begin
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                            rr_ptr_q  <= next_ptr;
                            stall_q   <= '0;
                            state_q   <= StIdle;
                        end else begin
                            stall_q <= stall_q + TO_W'(1);
                        end
                    end
                end
                StWaitDone: begin
                    // An over pulse coincident with our start strobe belongs to the previous byte.
                    if (uart_tx_over && !data_ready_q) begin
                        if (last_q) begin
                            busy_q   <= 1'b0;
                            rr_ptr_q <= next_ptr;
                            state_q  <= StIdle;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign uart_tx_data       = data_q;
    assign uart_tx_data_ready = data_ready_q;
    assign grant_ch           = grant_q;
    assign busy               = busy_q;
    assign timeout_err        = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N_CH byte-stream requesters (telemetry, debug, command-echo FIFOs).
- Grants one channel for a whole frame, delimited by ch_last.
- Pulls bytes one at a time and hands each to the transmitter via the uart_tx_status / uart_tx_over / uart_tx_data_ready handshake.
- Arbitration between frames is round-robin; a stalled channel is dropped after a timeout so it cannot lock the link.

Parameters:
- N_CH, 4, number of requester channels (2..8).
- CH_W, 2, width of grant_ch; equals clog2(N_CH).
- TIMEOUT_CYC, 1000, cycles a granted channel may hold ch_valid low mid-frame before being aborted.
- TO_W, 10, width of the stall counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- ch_data  in  N_CH*8  per-channel byte; channel i occupies bits [8i+7:8i]
- ch_valid  in  N_CH  per-channel byte available
- ch_last  in  N_CH  per-channel flag: current byte ends the frame
- ch_ready  out  N_CH  per-channel byte-accept strobe
- uart_tx_status  in  1  transmitter busy (high while shifting)
- uart_tx_over  in  1  one-cycle pulse when the transmitter finishes a byte
- uart_tx_data  out  8  byte to transmit
- uart_tx_data_ready  out  1  one-cycle start pulse to the transmitter
- grant_ch  out  CH_W  index of the channel currently owning the link
- busy  out  1  high while a frame is granted
- timeout_err  out  1  one-cycle pulse when a frame is aborted on stall

Behaviour:
- Reset (async): state=IDLE; rr_ptr=0. All outputs 0: ch_ready, uart_tx_data, uart_tx_data_ready, grant_ch, busy, timeout_err. Stall counter=0.
- States: IDLE, FETCH, WAIT_DONE.
- IDLE:
  - If any ch_valid is high, pick the first valid channel scanning upward from rr_ptr, modulo N_CH.
  - Register grant_ch and set busy=1; next state FETCH.
  - If no channel is valid, stay in IDLE.
- FETCH:
  - ch_ready[grant_ch] is combinational: ch_valid[grant_ch] & ~uart_tx_status & (state==FETCH).
  - ch_ready for every other channel is always 0.
  - On that handshake cycle: capture ch_data slice into uart_tx_data, capture ch_last into last_q, clear the stall counter.
  - Next cycle: uart_tx_data_ready=1 for exactly one cycle; state WAIT_DONE.
  - If ch_valid[grant_ch] is low, increment the stall counter.
  - When the counter reaches TIMEOUT_CYC: timeout_err pulses for one cycle, busy=0, rr_ptr=grant_ch+1 mod N_CH, state IDLE.
  - If uart_tx_status is high with data valid: wait; the stall counter does not increment.
- WAIT_DONE:
  - uart_tx_over is ignored in the same cycle uart_tx_data_ready is asserted.
  - On uart_tx_over with last_q=1: busy=0, rr_ptr=grant_ch+1 mod N_CH, state IDLE.
  - On uart_tx_over with last_q=0: state FETCH.
- Latency:
  - Single-channel timing: ch_valid rises at cycle T in IDLE with transmitter idle → grant_ch/busy valid at T+1, ch_ready high at T+1, uart_tx_data_ready at T+2.
  - Between bytes of one frame: uart_tx_over at cycle U → ch_ready at U+1 at the earliest, uart_tx_data_ready at U+2.
- uart_tx_data holds its value until the next capture; it is not cleared at end of frame.
- grant_ch holds the last granted value while in IDLE; it is only meaningful when busy=1.
- Fairness:
  - A frame is never preempted.
  - rr_ptr advances only at frame end or abort, so the channel just served has the lowest priority next.
- Simultaneous events:
  - All channels valid in IDLE → lowest index ≥ rr_ptr wins.
  - A byte with ch_last=1 accepted on a timeout-limit cycle counts as accepted; the handshake wins over the timeout.
- Single-byte frame (ch_last=1 on the first byte) completes normally.
- Reset mid-frame: the partially sent frame is abandoned; ch_ready drops immediately. The transmitter finishes any byte in flight on its own.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, WAIT_DONE=2'd2);
  - the byte width constant 8;
  - default N_CH and TIMEOUT_CYC.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req[N_CH], ptr[CH_W].
  - Outputs: grant_idx[CH_W], any_req.
  - Instantiated once from IDLE.

Test Plan:
- Single frame: ch1 sends 0xA5,0x5A(last); transmitter model asserts status for 10 cycles then pulses over → uart_tx_data sequence 0xA5,0x5A. uart_tx_data_ready exactly 2 pulses, the first at T+2. busy falls the cycle after the second over; grant_ch=1.
- Round-robin: ch0, ch2 and ch3 each hold a 1-byte frame at reset release → grant order 0,2,3. Then, after ch0 requeues, grant order 0 again only after ch3.
- Non-preemption: ch3 sends a 4-byte frame while ch0 raises valid after byte 1 → all 4 ch3 bytes go out contiguously, then ch0 is granted.
- Stall timeout: ch2 sends byte 0x11 (last=0) then holds valid low; TIMEOUT_CYC=16 → timeout_err pulse after 16 FETCH cycles, busy=0, next grant starts at ch3.
- Busy back-pressure: uart_tx_status held high for 50 cycles while ch0 is valid in FETCH → ch_ready stays 0, no timeout_err, byte accepted on the cycle after status falls.
- Reset mid-frame: assert rst_n low during WAIT_DONE of byte 2 → all outputs 0 asynchronously. After release, state IDLE and rr_ptr=0.
